// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - sequential binary-to-BCD converter driving a 4-digit common-anode seven-segment scan
module ssd_scan_driver #(
  parameter int REFRESH_BITS = 18,
  parameter int BLANK_LZ     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  segments,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  // 16 BCD bits on top of the 13 binary bits being shifted in.
  logic [28:0]             r_sr;
  logic [28:0]             w_adj;
  logic [28:0]             w_next_sr;
  logic [3:0]              r_iter;
  logic [12:0]             r_val;
  logic [12:0]             r_last_val;
  logic [3:0]              r_d0;
  logic [3:0]              r_d1;
  logic [3:0]              r_d2;
  logic [3:0]              r_d3;

  logic [REFRESH_BITS-1:0] r_cnt;
  logic [1:0]              w_sel;
  logic [3:0]              w_digit;
  logic                    w_blank;
  logic [3:0]              w_anode;
  logic [6:0]              w_seg;
  logic [3:0]              r_anode;
  logic [6:0]              r_seg;

  logic                    w_start;

  assign w_start  = (value != r_last_val);
  assign busy     = (r_state != ST_IDLE);
  assign anode    = r_anode;
  assign segments = r_seg;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // State register for the convert sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: start on a changed value, 13 dabble iterations, then one publish cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next_state = ST_CONV;
      ST_CONV: if (r_iter == 4'd12) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the whole register left.
  always_comb begin
    w_adj = r_sr;
    for (int i = 0; i < 4; i++) begin
      if (r_sr[13 + 4*i +: 4] >= 4'd5) begin
        w_adj[13 + 4*i +: 4] = r_sr[13 + 4*i +: 4] + 4'd3;
      end
    end
    w_next_sr = w_adj << 1;
  end

  // Conversion datapath; displayed digits only change in DONE so no partial value is ever shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr       <= '0;
      r_iter     <= '0;
      r_val      <= '0;
      r_last_val <= '0;
      r_d0       <= '0;
      r_d1       <= '0;
      r_d2       <= '0;
      r_d3       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_sr   <= {16'd0, value};
            r_iter <= '0;
            r_val  <= value;
          end
        end
        ST_CONV: begin
          r_sr   <= w_next_sr;
          r_iter <= r_iter + 4'd1;
        end
        ST_DONE: begin
          r_d0       <= r_sr[16:13];
          r_d1       <= r_sr[20:17];
          r_d2       <= r_sr[24:21];
          r_d3       <= r_sr[28:25];
          r_last_val <= r_val;
        end
        default: ;
      endcase
    end
  end

  // Free-running refresh counter; its top two bits pick the digit being scanned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + REFRESH_BITS'(1);
    end
  end

  assign w_sel = r_cnt[REFRESH_BITS-1:REFRESH_BITS-2];

  // Select the scanned digit, decide leading-zero blanking and build the raw pin patterns.
  always_comb begin
    w_digit = r_d0;
    w_blank = 1'b0;
    w_anode = 4'b1110;
    case (w_sel)
      2'd0: begin
        w_digit = r_d0;
        w_blank = 1'b0;
        w_anode = 4'b1110;
      end
      2'd1: begin
        w_digit = r_d1;
        w_blank = ({r_d3, r_d2, r_d1} == 12'd0);
        w_anode = 4'b1101;
      end
      2'd2: begin
        w_digit = r_d2;
        w_blank = ({r_d3, r_d2} == 8'd0);
        w_anode = 4'b1011;
      end
      default: begin
        w_digit = r_d3;
        w_blank = (r_d3 == 4'd0);
        w_anode = 4'b0111;
      end
    endcase
    if ((BLANK_LZ != 0) && w_blank) begin
      w_seg = 7'b1111111;
    end else begin
      w_seg = f_seg(w_digit);
    end
  end

  // Register the display pins so they are glitch-free; all segments and digits dark in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_anode <= 4'b1111;
      r_seg   <= 7'b1111111;
    end else begin
      r_anode <= w_anode;
      r_seg   <= w_seg;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - randomized model-checked bench for ssd_scan_driver
module tb_ssd_scan_driver;

  localparam int RB   = 4;
  localparam int HOLD = 2 ** (RB - 2);

  logic        clk;
  logic        rst;
  logic [12:0] value;
  logic [3:0]  an1, an0;
  logic [6:0]  seg1, seg0;
  logic        busy1, busy0;

  int n_pass;
  int n_total;

  ssd_scan_driver #(.REFRESH_BITS(RB), .BLANK_LZ(1)) u_dut_lz1 (
    .clk(clk), .rst(rst), .value(value),
    .anode(an1), .segments(seg1), .busy(busy1)
  );

  ssd_scan_driver #(.REFRESH_BITS(RB), .BLANK_LZ(0)) u_dut_lz0 (
    .clk(clk), .rst(rst), .value(value),
    .anode(an0), .segments(seg0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display glyphs indexed by decimal digit, gfedcba active-low.
  logic [6:0] seg_tab [10];
  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
  end

  function automatic int pow10(input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] glyph(input int v, input int k, input bit lz);
    if (lz && k > 0 && v < pow10(k)) return 7'b1111111;
    return seg_tab[(v / pow10(k)) % 10];
  endfunction

  // Behavioural model: a conversion is a 14-cycle busy window after which the latched value is shown.
  bit         m_valid;
  int         m_ref;
  int         m_timer;
  int         m_disp;
  int         m_last;
  int         m_pend;
  logic [3:0] m_an;
  logic [6:0] m_seg1, m_seg0;

  initial begin
    m_valid = 0; m_ref = 0; m_timer = 0; m_disp = 0; m_last = 0; m_pend = 0;
    m_an = 4'hf; m_seg1 = 7'h7f; m_seg0 = 7'h7f;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1;
      m_ref   <= 0;
      m_timer <= 0;
      m_disp  <= 0;
      m_last  <= 0;
      m_an    <= 4'b1111;
      m_seg1  <= 7'b1111111;
      m_seg0  <= 7'b1111111;
    end else begin
      m_an   <= ~(4'b0001 << (m_ref / HOLD));
      m_seg1 <= glyph(m_disp, m_ref / HOLD, 1'b1);
      m_seg0 <= glyph(m_disp, m_ref / HOLD, 1'b0);
      m_ref  <= (m_ref + 1) % (2 ** RB);
      if (m_timer == 0) begin
        if (int'(value) != m_last) begin
          m_pend  <= int'(value);
          m_timer <= 14;
        end
      end else begin
        m_timer <= m_timer - 1;
        if (m_timer == 1) begin
          m_disp <= m_pend;
          m_last <= m_pend;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Cycle-by-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("anode_lz1", 32'(an1), 32'(m_an));
      chk("seg_lz1",   32'(seg1), 32'(m_seg1));
      chk("busy_lz1",  32'(busy1), 32'(m_timer != 0));
      chk("anode_lz0", 32'(an0), 32'(m_an));
      chk("seg_lz0",   32'(seg0), 32'(m_seg0));
      chk("busy_lz0",  32'(busy0), 32'(m_timer != 0));
    end
  end

  task automatic check_scan(input logic [3:0] an, input logic [6:0] s1, input logic [6:0] s0,
                            input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (an1 !== an && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_an"},  32'(an1),  32'(an));
    chk({nm, "_lz1"}, 32'(seg1), 32'(s1));
    chk({nm, "_lz0"}, 32'(seg0), 32'(s0));
  endtask

  task automatic set_and_settle(input logic [12:0] v);
    @(negedge clk);
    value = v;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    value   = 13'd0;
    repeat (2) @(negedge clk);
    chk("reset_anode", 32'(an1), 32'hf);
    chk("reset_seg",   32'(seg1), 32'h7f);
    chk("reset_busy",  32'(busy1), 32'h0);
    rst = 1'b0;

    check_scan(4'b1110, 7'b1000000, 7'b1000000, "zero_units");
    check_scan(4'b1101, 7'b1111111, 7'b1000000, "zero_tens");
    chk("zero_no_conv", 32'(busy1), 32'h0);

    set_and_settle(13'd1234);
    chk("model_1234", 32'(m_disp), 32'd1234);
    check_scan(4'b1110, 7'b0011001, 7'b0011001, "s1234_d0");
    check_scan(4'b1101, 7'b0110000, 7'b0110000, "s1234_d1");
    check_scan(4'b1011, 7'b0100100, 7'b0100100, "s1234_d2");
    check_scan(4'b0111, 7'b1111001, 7'b1111001, "s1234_d3");

    set_and_settle(13'd8191);
    check_scan(4'b0111, 7'b0000000, 7'b0000000, "s8191_d3");
    check_scan(4'b1110, 7'b1111001, 7'b1111001, "s8191_d0");

    set_and_settle(13'd7);
    check_scan(4'b1110, 7'b1111000, 7'b1111000, "s7_d0");
    check_scan(4'b1011, 7'b1111111, 7'b1000000, "s7_d2");
    check_scan(4'b0111, 7'b1111111, 7'b1000000, "s7_d3");

    set_and_settle(13'd100);
    check_scan(4'b0111, 7'b1111111, 7'b1000000, "s100_d3");
    check_scan(4'b1011, 7'b1111001, 7'b1111001, "s100_d2");
    check_scan(4'b1101, 7'b1000000, 7'b1000000, "s100_d1");
    check_scan(4'b1110, 7'b1000000, 7'b1000000, "s100_d0");

    // Change while busy: E0 is the edge after this negedge.
    @(negedge clk);
    value = 13'd1234;
    repeat (5) @(negedge clk);
    value = 13'd5678;
    repeat (9) @(negedge clk);
    chk("chg_busy_e13", 32'(busy1), 32'h1);
    @(negedge clk);
    chk("chg_busy_e14", 32'(busy1), 32'h0);
    chk("chg_model_1234", 32'(m_disp), 32'd1234);
    @(negedge clk);
    chk("chg_busy_e15", 32'(busy1), 32'h1);
    repeat (14) @(negedge clk);
    chk("chg_busy_end", 32'(busy1), 32'h0);
    chk("chg_model_5678", 32'(m_disp), 32'd5678);
    check_scan(4'b1110, 7'b0000000, 7'b0000000, "s5678_d0");
    check_scan(4'b0111, 7'b0010010, 7'b0010010, "s5678_d3");

    // Reset during a conversion.
    @(negedge clk);
    value = 13'd4321;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy1), 32'h0);
    chk("rstmid_anode", 32'(an1), 32'hf);
    rst = 1'b0;
    check_scan(4'b1110, 7'b1000000, 7'b1000000, "rstmid_d0");
    check_scan(4'b0111, 7'b1111111, 7'b1000000, "rstmid_d3");
    repeat (20) @(negedge clk);
    check_scan(4'b0111, 7'b0011001, 7'b0011001, "s4321_d3");
    check_scan(4'b1110, 7'b1111001, 7'b1111001, "s4321_d0");

    // Randomized phase: arbitrary values, hold times and occasional resets.
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) value = 13'($urandom_range(0, 120));
      else value = 13'($urandom_range(0, 8191));
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
